ball_centroid_tracker: RTL and testbench

Downstream consumer of the camera capture stage's RGB565 pixel stream (data/write-enable pair, same pixel clock) in the ball-tracking design. Classifies each pixel against a colour threshold, accumulates the coordinates of matching pixels over a 320×240 frame, and at frame end computes the integer centroid with a sequential divider. It also emits a per-pixel binary mask stream, one cycle delayed, for a debug/overlay frame buffer.

---
 rtl/ball_track_pkg.sv | 17 +
 rtl/seq_divider.sv | 67 ++++++
 rtl/ball_centroid_tracker.sv | 200 ++++++++++++++++++++
 tb/tb_ball_centroid_tracker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_track_pkg.sv
// Shared constants and FSM encoding for the ball centroid tracker.
// Frame geometry, accumulator widths and the result FSM state type.
package ball_track_pkg;

    localparam int H_ACTIVE = 320;
    localparam int V_ACTIVE = 240;

    localparam int SUM_W = 25;
    localparam int CNT_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } trk_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// Ports: pclk, rst (async high), start/dividend/divisor in,
//        done (final step this cycle), quotient (valid with done).
module seq_divider #(
    parameter int DIVIDEND_W = 25,
    parameter int DIVISOR_W  = 17
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int STEP_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVIDEND_W-1:0] quo_n;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVISOR_W-1:0]  rem_n;
    logic [DIVISOR_W-1:0]  dsr_q;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;
    logic [STEP_W-1:0]     step_q;
    logic                  run_q;
    logic                  ge;

    // Remainder stays below the divisor, so it fits in DIVISOR_W
    // bits; one extra bit is needed only for the shifted trial.
    always_comb begin
        trial = {rem_q, quo_q[DIVIDEND_W-1]};
        diff  = trial - {1'b0, dsr_q};
        ge    = (trial >= {1'b0, dsr_q});
        rem_n = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
        quo_n = {quo_q[DIVIDEND_W-2:0], ge};
    end

    // The last step's result is offered combinationally so the
    // caller can register it in the same cycle as done.
    assign done     = run_q && (step_q == STEP_W'(DIVIDEND_W - 1));
    assign quotient = quo_n;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dsr_q  <= divisor;
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            quo_q  <= quo_n;
            rem_q  <= rem_n;
            step_q <= step_q + 1'b1;
            if (done)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ball_centroid_tracker.sv
// Colour-threshold ball tracker: per-pixel mask plus frame centroid.
// Ports: pclk, rst, vsync/we/din in; mask_we/mask_dout,
//        ball_x/ball_y/pixel_count/found/result_valid/busy out.
module ball_centroid_tracker #(
    parameter int          H_ACTIVE   = ball_track_pkg::H_ACTIVE,
    parameter int          V_ACTIVE   = ball_track_pkg::V_ACTIVE,
    parameter logic [4:0]  R_MIN      = 5'd20,
    parameter logic [5:0]  G_MAX      = 6'd24,
    parameter logic [4:0]  B_MAX      = 5'd12,
    parameter logic [16:0] MIN_PIXELS = 17'd16
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        we,
    input  logic [15:0] din,
    output logic        mask_we,
    output logic [15:0] mask_dout,
    output logic [8:0]  ball_x,
    output logic [7:0]  ball_y,
    output logic [16:0] pixel_count,
    output logic        found,
    output logic        result_valid,
    output logic        busy
);

    import ball_track_pkg::*;

    logic             vsync_d;
    logic [8:0]       x_cnt;
    logic [7:0]       y_cnt;
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] snap_cnt;

    logic in_frame;
    logic pix_ok;
    logic colour_hit;
    logic hit;
    logic frame_end;
    logic below_min;

    trk_state_t state_q;
    trk_state_t state_d;
    logic       div_start;
    logic       done_x;
    logic       done_y;
    logic       div_done;

    logic [SUM_W-1:0] quo_x;
    logic [SUM_W-1:0] quo_y;
    logic             unused_quo;

    assign in_frame   = (y_cnt < 8'(V_ACTIVE));
    assign pix_ok     = we && !vsync && in_frame;
    assign colour_hit = (din[15:11] >= R_MIN)
                     && (din[10:5]  <= G_MAX)
                     && (din[4:0]   <= B_MAX);
    assign hit        = pix_ok && colour_hit;
    assign frame_end  = vsync && !vsync_d;
    assign below_min  = (acc_cnt < MIN_PIXELS);
    assign div_done   = done_x && done_y;
    assign unused_quo = ^{quo_x[SUM_W-1:9], quo_y[SUM_W-1:8]};

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            vsync_d <= 1'b0;
        else
            vsync_d <= vsync;
    end

    // Raster position; once y_cnt reaches V_ACTIVE it stays there
    // until blanking, so surplus strobes are dropped.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vsync) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_ok) begin
            if (x_cnt == 9'(H_ACTIVE - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 8'd1;
            end else begin
                x_cnt <= x_cnt + 9'd1;
            end
        end
    end

    // hit needs vsync low and frame_end needs it high, so the
    // clear and the add never collide.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sum_x   <= '0;
            sum_y   <= '0;
            acc_cnt <= '0;
        end else if (frame_end) begin
            sum_x   <= '0;
            sum_y   <= '0;
            acc_cnt <= '0;
        end else if (hit) begin
            sum_x   <= sum_x + SUM_W'(x_cnt);
            sum_y   <= sum_y + SUM_W'(y_cnt);
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            snap_cnt <= '0;
        else if (frame_end)
            snap_cnt <= acc_cnt;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            mask_we   <= 1'b0;
            mask_dout <= '0;
        end else begin
            mask_we   <= we;
            mask_dout <= {16{hit}};
        end
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div_x (
        .pclk     (pclk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_x),
        .divisor  (acc_cnt),
        .done     (done_x),
        .quotient (quo_x)
    );

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div_y (
        .pclk     (pclk),
        .rst      (rst),
        .start    (div_start),
        .dividend (sum_y),
        .divisor  (acc_cnt),
        .done     (done_y),
        .quotient (quo_y)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // A new frame edge overrides whatever is in flight, which is
    // how an unfinished division gets abandoned.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        if (frame_end) begin
            div_start = !below_min;
            state_d   = below_min ? ST_DONE : ST_DIV;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DIV:  if (div_done) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Results are written on the way into DONE so they appear
    // together with result_valid.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            ball_x      <= '0;
            ball_y      <= '0;
            pixel_count <= '0;
            found       <= 1'b0;
        end else if (frame_end && below_min) begin
            pixel_count <= acc_cnt;
            found       <= 1'b0;
        end else if (state_q == ST_DIV && div_done) begin
            ball_x      <= quo_x[8:0];
            ball_y      <= quo_y[7:0];
            pixel_count <= snap_cnt;
            found       <= 1'b1;
        end
    end

    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q == ST_DIV);

endmodule

// File: tb/tb_ball_centroid_tracker.sv
// Directed frame-level bench for ball_centroid_tracker.
// Two instances: default threshold (a) and MIN_PIXELS=1 (b).
module tb_ball_centroid_tracker;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        rst_a, vs_a, we_a;
    logic [15:0] din_a;
    logic        mwe_a, fnd_a, rv_a, bsy_a;
    logic [15:0] md_a;
    logic [8:0]  bx_a;
    logic [7:0]  by_a;
    logic [16:0] pc_a;

    logic        rst_b, vs_b, we_b;
    logic [15:0] din_b;
    logic        mwe_b, fnd_b, rv_b, bsy_b;
    logic [15:0] md_b;
    logic [8:0]  bx_b;
    logic [7:0]  by_b;
    logic [16:0] pc_b;

    ball_centroid_tracker dut_a (
        .pclk         (pclk),
        .rst          (rst_a),
        .vsync        (vs_a),
        .we           (we_a),
        .din          (din_a),
        .mask_we      (mwe_a),
        .mask_dout    (md_a),
        .ball_x       (bx_a),
        .ball_y       (by_a),
        .pixel_count  (pc_a),
        .found        (fnd_a),
        .result_valid (rv_a),
        .busy         (bsy_a)
    );

    ball_centroid_tracker #(
        .MIN_PIXELS (17'd1)
    ) dut_b (
        .pclk         (pclk),
        .rst          (rst_b),
        .vsync        (vs_b),
        .we           (we_b),
        .din          (din_b),
        .mask_we      (mwe_b),
        .mask_dout    (md_b),
        .ball_x       (bx_b),
        .ball_y       (by_b),
        .pixel_count  (pc_b),
        .found        (fnd_b),
        .result_valid (rv_b),
        .busy         (bsy_b)
    );

    typedef struct {
        int          dut;
        bit          pre_rst;
        int          x0, x1, y0, y1;
        logic [15:0] fg, bg;
        int          npix;
        bit          mhot;
        int          lat, bx, by, cnt, fnd;
    } frame_t;

    localparam int NREC = 7;
    frame_t tbl[NREC];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    function automatic int g_x(input int d);
        return d == 0 ? int'(bx_a) : int'(bx_b);
    endfunction
    function automatic int g_y(input int d);
        return d == 0 ? int'(by_a) : int'(by_b);
    endfunction
    function automatic int g_cnt(input int d);
        return d == 0 ? int'(pc_a) : int'(pc_b);
    endfunction
    function automatic int g_fnd(input int d);
        return d == 0 ? int'(fnd_a) : int'(fnd_b);
    endfunction
    function automatic bit g_rv(input int d);
        return d == 0 ? rv_a : rv_b;
    endfunction
    function automatic bit g_busy(input int d);
        return d == 0 ? bsy_a : bsy_b;
    endfunction
    function automatic int g_mask(input int d);
        return d == 0 ? int'({mwe_a, md_a}) : int'({mwe_b, md_b});
    endfunction
    function automatic int g_flags(input int d);
        return d == 0 ? int'({fnd_a, rv_a, bsy_a, mwe_a})
                      : int'({fnd_b, rv_b, bsy_b, mwe_b});
    endfunction

    task automatic drv(input int d, input logic v, input logic w,
                       input logic [15:0] p);
        if (d == 0) begin
            vs_a = v; we_a = w; din_a = p;
        end else begin
            vs_b = v; we_b = w; din_b = p;
        end
    endtask

    task automatic chk_zero(input int d, input string pfx);
        chk({pfx, "_x"}, g_x(d), 0);
        chk({pfx, "_y"}, g_y(d), 0);
        chk({pfx, "_cnt"}, g_cnt(d), 0);
        chk({pfx, "_flags"}, g_flags(d), 0);
        chk({pfx, "_mask"}, g_mask(d), 0);
    endtask

    // Blanking preamble carries stray red strobes that must be
    // ignored; ends by driving the vsync edge cycle.
    task automatic feed(input int d, input frame_t r, input string nm);
        int  merr, x, y;
        bit  hot, hot_prev;
        merr = 0;
        hot_prev = 1'b0;
        repeat (2) begin
            @(negedge pclk);
            drv(d, 1'b1, 1'b1, 16'hF800);
        end
        for (int i = 0; i < r.npix; i++) begin
            @(negedge pclk);
            if (g_mask(d) != int'({1'b1, {16{hot_prev}}}))
                merr++;
            x = i % 320;
            y = i / 320;
            hot = (x >= r.x0) && (x <= r.x1)
               && (y >= r.y0) && (y <= r.y1);
            drv(d, 1'b0, 1'b1, hot ? r.fg : r.bg);
            hot_prev = hot && r.mhot && (i < 76800);
        end
        @(negedge pclk);
        if (g_mask(d) != int'({1'b1, {16{hot_prev}}}))
            merr++;
        drv(d, 1'b1, 1'b0, 16'h0000);
        chk({nm, "_mask"}, merr, 0);
    endtask

    // Observes E+1..E+40 after the edge cycle just driven.
    task automatic watch(input int d, input string nm, input int lat,
                         input int bx, input int by, input int cnt,
                         input int fnd);
        int first, nrv, nbusy, gx, gy, gc, gf;
        first = -1; nrv = 0; nbusy = 0;
        gx = -1; gy = -1; gc = -1; gf = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge pclk);
            if (g_busy(d)) nbusy++;
            if (g_rv(d)) begin
                nrv++;
                if (first < 0) begin
                    first = n;
                    gx = g_x(d); gy = g_y(d);
                    gc = g_cnt(d); gf = g_fnd(d);
                end
            end
        end
        chk({nm, "_lat"}, first, lat);
        chk({nm, "_pulses"}, nrv, 1);
        chk({nm, "_busy"}, nbusy, (lat == 26) ? 25 : 0);
        chk({nm, "_x"}, gx, bx);
        chk({nm, "_y"}, gy, by);
        chk({nm, "_cnt"}, gc, cnt);
        chk({nm, "_found"}, gf, fnd);
    endtask

    task automatic mid_reset();
        repeat (2) begin
            @(negedge pclk);
            drv(0, 1'b1, 1'b0, 16'h0000);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            drv(0, 1'b0, 1'b1, 16'hF800);
        end
        @(negedge pclk);
        drv(0, 1'b1, 1'b0, 16'h0000);
        repeat (5) @(negedge pclk);
        chk("mrst_busy_before", int'(g_busy(0)), 1);
        #2 rst_a = 1'b1;
        #1;
        chk_zero(0, "mrst");
        @(negedge pclk);
        drv(0, 1'b0, 1'b0, 16'h0000);
        @(negedge pclk);
        rst_a = 1'b0;
    endtask

    task automatic abort_seq();
        int nrv;
        repeat (2) begin
            @(negedge pclk);
            drv(1, 1'b1, 1'b0, 16'h0000);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            drv(1, 1'b0, 1'b1, 16'hF800);
        end
        @(negedge pclk);
        drv(1, 1'b1, 1'b0, 16'h0000);
        nrv = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge pclk);
            if (g_rv(1)) nrv++;
            drv(1, 1'b0, 1'b1, (k >= 6) ? 16'hF800 : 16'h0000);
        end
        @(negedge pclk);
        if (g_rv(1)) nrv++;
        drv(1, 1'b1, 1'b0, 16'h0000);
        chk("abort_quiet", nrv, 0);
        watch(1, "abort", 26, 7, 0, 3, 1);
    endtask

    task automatic run_rec(input frame_t r, input int idx);
        string nm;
        nm = $sformatf("rec%0d", idx);
        if (r.pre_rst)
            mid_reset();
        feed(r.dut, r, nm);
        watch(r.dut, nm, r.lat, r.bx, r.by, r.cnt, r.fnd);
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 0, 319, 0, 255, 16'hF800, 16'h0000,
                   80000, 1'b1, 26, 159, 119, 76800, 1};
        tbl[1] = '{0, 1'b0, 0, 4, 0, 0, 16'hF800, 16'h0000,
                   5, 1'b1, 1, 159, 119, 5, 0};
        tbl[2] = '{0, 1'b0, 0, 319, 0, 255, 16'h07E0, 16'h0000,
                   640, 1'b0, 1, 159, 119, 0, 0};
        tbl[3] = '{0, 1'b1, 0, 19, 0, 0, 16'hF800, 16'h0000,
                   20, 1'b1, 26, 9, 0, 20, 1};
        tbl[4] = '{1, 1'b0, 10, 10, 20, 20, 16'hF800, 16'h9800,
                   6411, 1'b1, 26, 10, 20, 1, 1};
        tbl[5] = '{1, 1'b0, 100, 109, 50, 59, 16'hF800, 16'hFB20,
                   18990, 1'b1, 26, 104, 54, 100, 1};
        tbl[6] = '{1, 1'b0, 0, 4, 0, 0, 16'hA30C, 16'hF80D,
                   8, 1'b1, 26, 2, 0, 5, 1};

        rst_a = 1'b1;
        rst_b = 1'b1;
        drv(0, 1'b1, 1'b0, 16'h0000);
        drv(1, 1'b1, 1'b0, 16'h0000);
        repeat (3) @(negedge pclk);
        chk_zero(0, "rst_a");
        chk_zero(1, "rst_b");
        rst_a = 1'b0;
        rst_b = 1'b0;

        fork
            begin
                for (int i = 0; i < NREC; i++)
                    if (tbl[i].dut == 0)
                        run_rec(tbl[i], i);
            end
            begin
                for (int j = 0; j < NREC; j++)
                    if (tbl[j].dut == 1)
                        run_rec(tbl[j], j);
                abort_seq();
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
